// File: rtl/pong_nios_oci_dct_pkg.sv
// Shared definitions for the Nios OCI DCT trace sequencer: state encoding and
// buffer geometry.
package pong_nios_oci_dct_pkg;

    localparam int DCT_CODE_W = 2;
    localparam int DCT_DEPTH  = 15;
    localparam int DCT_BUF_W  = DCT_CODE_W * DCT_DEPTH;

    typedef enum logic [1:0] {
        DCT_FILL   = 2'd0,
        DCT_EMIT   = 2'd1,
        DCT_ENDING = 2'd2,
        DCT_ENDED  = 2'd3
    } dct_state_e;

endpackage

// File: rtl/pong_nios_oci_dct_packer.sv
// Packs trace codes LSB-first into the DCT buffer and tracks how many slots
// are occupied.
module pong_nios_oci_dct_packer
    import pong_nios_oci_dct_pkg::*;
#(
    parameter int CODE_W  = DCT_CODE_W,
    parameter int DEPTH   = DCT_DEPTH,
    parameter int COUNT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      clear,
    input  logic [CODE_W-1:0]         code,
    output logic [CODE_W*DEPTH-1:0]   buffer,
    output logic [COUNT_W-1:0]        count,
    output logic                      full
);

    logic [CODE_W*DEPTH-1:0] buffer_q, buffer_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic                    has_room;

    assign has_room = (count_q < COUNT_W'(DEPTH));

    always_comb begin
        buffer_d = buffer_q;
        count_d  = count_q;
        if (clear) begin
            buffer_d = '0;
            count_d  = '0;
        end else if (push && has_room) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == COUNT_W'(i)) begin
                    buffer_d[i*CODE_W +: CODE_W] = code;
                end
            end
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

    // High when the push happening this cycle lands in the last free slot.
    assign full   = push && !clear && (count_q == COUNT_W'(DEPTH - 1));
    assign buffer = buffer_q;
    assign count  = count_q;

endmodule

// File: rtl/pong_nios_oci_dct_sequencer.sv
// DCT sequencer top: fills frames of trace codes, hands them downstream over
// valid/ready, and runs the end-of-test drain.
module pong_nios_oci_dct_sequencer
    import pong_nios_oci_dct_pkg::*;
#(
    parameter int CODE_W  = DCT_CODE_W,
    parameter int DEPTH   = DCT_DEPTH,
    parameter int COUNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     code_valid,
    input  logic [CODE_W-1:0]        code_data,
    output logic                     code_ready,
    input  logic                     flush,
    input  logic                     end_req,
    output logic                     frame_valid,
    output logic [CODE_W*DEPTH-1:0]  frame_data,
    output logic [COUNT_W-1:0]       frame_count,
    input  logic                     frame_ready,
    output logic [CODE_W*DEPTH-1:0]  dct_buffer,
    output logic [COUNT_W-1:0]       dct_count,
    output logic                     test_ending,
    output logic                     test_has_ended
);

    dct_state_e state_q, state_d;
    logic       end_pending_q, end_pending_d;
    logic       test_has_ended_q;
    logic       push, clear, full, has_codes;

    logic [CODE_W*DEPTH-1:0] buffer;
    logic [COUNT_W-1:0]      count;

    pong_nios_oci_dct_packer #(
        .CODE_W  (CODE_W),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_packer (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .clear  (clear),
        .code   (code_data),
        .buffer (buffer),
        .count  (count),
        .full   (full)
    );

    // A code accepted together with flush/end_req belongs to the emitted frame.
    assign has_codes = code_valid || (count != '0);

    always_comb begin
        state_d       = state_q;
        end_pending_d = end_pending_q;
        push          = 1'b0;
        clear         = 1'b0;
        case (state_q)
            DCT_FILL: begin
                push = code_valid;
                if (end_req) begin
                    end_pending_d = 1'b1;
                end
                if (full) begin
                    state_d = DCT_EMIT;
                end else if ((flush || end_req) && has_codes) begin
                    state_d = DCT_EMIT;
                end else if (end_req) begin
                    state_d = DCT_ENDING;
                end
            end
            DCT_EMIT: begin
                if (end_req) begin
                    end_pending_d = 1'b1;
                end
                if (frame_ready) begin
                    clear   = 1'b1;
                    state_d = (end_pending_q || end_req) ? DCT_ENDING : DCT_FILL;
                end
            end
            DCT_ENDING: begin
                state_d = DCT_ENDED;
            end
            DCT_ENDED: begin
                state_d = DCT_ENDED;
            end
            default: begin
                state_d = DCT_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= DCT_FILL;
            end_pending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            end_pending_q    <= end_pending_d;
            test_has_ended_q <= test_has_ended_q || (state_d == DCT_ENDED);
        end
    end

    // The frame is the buffer itself; it cannot change while EMIT holds off pushes.
    assign code_ready     = (state_q == DCT_FILL);
    assign frame_valid    = (state_q == DCT_EMIT);
    assign frame_data     = buffer;
    assign frame_count    = count;
    assign dct_buffer     = buffer;
    assign dct_count      = count;
    assign test_ending    = end_pending_q;
    assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_pong_nios_oci_dct_sequencer.sv
// Self-checking bench for the DCT sequencer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_pong_nios_oci_dct_sequencer;

    logic        clk;
    logic        reset;
    logic        code_valid;
    logic [1:0]  code_data;
    logic        code_ready;
    logic        flush;
    logic        end_req;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    int errors = 0;
    int checks = 0;

    pong_nios_oci_dct_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .code_valid     (code_valid),
        .code_data      (code_data),
        .code_ready     (code_ready),
        .flush          (flush),
        .end_req        (end_req),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the accepted codes of the current frame plus a few flags.
    logic [1:0] mCodes[$];
    bit         mEmitting;
    bit         mPending;
    bit         mEnding;
    bit         mEnded;

    function automatic logic [29:0] packCodes();
        logic [29:0] r = '0;
        foreach (mCodes[i]) r[2*i +: 2] = mCodes[i];
        return r;
    endfunction

    function automatic void modelReset();
        mCodes.delete();
        mEmitting = 0;
        mPending  = 0;
        mEnding   = 0;
        mEnded    = 0;
    endfunction

    function automatic void modelStep(bit cv, logic [1:0] cd, bit fl, bit er, bit fr);
        if (mEnded) begin
            return;
        end
        if (mEnding) begin
            mEnding = 0;
            mEnded  = 1;
            return;
        end
        if (er) mPending = 1;
        if (mEmitting) begin
            if (fr) begin
                mCodes.delete();
                mEmitting = 0;
                if (mPending) mEnding = 1;
            end
        end else begin
            if (cv) mCodes.push_back(cd);
            if (mCodes.size() == 15) mEmitting = 1;
            else if ((fl || er) && mCodes.size() > 0) mEmitting = 1;
            else if (er) mEnding = 1;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        bit filling;
        filling = !mEmitting && !mEnding && !mEnded;
        checkOutput({tag, ".code_ready"},     32'(code_ready),     32'(filling));
        checkOutput({tag, ".frame_valid"},    32'(frame_valid),    32'(mEmitting));
        checkOutput({tag, ".frame_data"},     32'(frame_data),     32'(packCodes()));
        checkOutput({tag, ".frame_count"},    32'(frame_count),    32'(mCodes.size()));
        checkOutput({tag, ".dct_buffer"},     32'(dct_buffer),     32'(packCodes()));
        checkOutput({tag, ".dct_count"},      32'(dct_count),      32'(mCodes.size()));
        checkOutput({tag, ".test_ending"},    32'(test_ending),    32'(mPending));
        checkOutput({tag, ".test_has_ended"}, 32'(test_has_ended), 32'(mEnded));
    endtask

    // Drives one cycle of inputs, checks the current outputs mid-cycle, then
    // advances the model by the same inputs at the clock edge.
    task automatic applyStimulus(input string tag, input bit cv, input logic [1:0] cd,
                                 input bit fl, input bit er, input bit fr);
        code_valid  = cv;
        code_data   = cd;
        flush       = fl;
        end_req     = er;
        frame_ready = fr;
        @(negedge clk);
        checkAll(tag);
        modelStep(cv, cd, fl, er, fr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n, input bit fr);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 2'd0, 0, 0, fr);
    endtask

    initial begin
        reset       = 1'b1;
        code_valid  = 1'b0;
        code_data   = 2'd0;
        flush       = 1'b0;
        end_req     = 1'b0;
        frame_ready = 1'b0;
        modelReset();
        #12;
        checkAll("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full frame of the repeating 0,1,2,3 pattern, drained immediately.
        for (int i = 0; i < 15; i++) applyStimulus("full15", 1, 2'(i % 4), 0, 0, 1);
        idle("full15.drain", 3, 1);

        // Partial frame emitted by flush.
        applyStimulus("flush3", 1, 2'd3, 0, 0, 1);
        applyStimulus("flush3", 1, 2'd3, 0, 0, 1);
        applyStimulus("flush3", 1, 2'd1, 0, 0, 0);
        applyStimulus("flush3", 0, 2'd0, 1, 0, 0);
        applyStimulus("flush3.emit", 0, 2'd0, 0, 0, 1);
        idle("flush3.after", 2, 1);

        // Flush with nothing buffered is ignored.
        applyStimulus("flush0", 0, 2'd0, 1, 0, 1);
        idle("flush0.after", 2, 1);

        // Backpressure: frame held while code_valid stays high.
        for (int i = 0; i < 15; i++) applyStimulus("stall.fill", 1, 2'($urandom_range(0, 3)), 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus("stall.hold", 1, 2'($urandom_range(0, 3)), 0, 0, 0);
        applyStimulus("stall.release", 1, 2'd2, 0, 0, 1);
        idle("stall.after", 2, 0);
        idle("stall.after", 1, 1);

        // Random traffic without end-of-test.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random", bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), 0, bit'($urandom_range(0, 1)));
        end
        idle("random.drain", 2, 1);

        // Asynchronous reset while a 7-code frame sits in EMIT.
        for (int i = 0; i < 7; i++) applyStimulus("rstmid.fill", 1, 2'($urandom_range(0, 3)), 0, 0, 0);
        applyStimulus("rstmid.flush", 0, 2'd0, 1, 0, 0);
        applyStimulus("rstmid.emit", 0, 2'd0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("rstmid.async");
        @(negedge clk);
        checkAll("rstmid.held");
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("fresh", 1, 2'd2, 0, 0, 0);
        applyStimulus("fresh", 1, 2'd1, 0, 0, 0);
        applyStimulus("fresh", 0, 2'd0, 1, 0, 0);
        applyStimulus("fresh.emit", 0, 2'd0, 0, 0, 1);
        idle("fresh.after", 2, 1);

        // End of test after 5 codes; later codes must never be taken.
        for (int i = 0; i < 5; i++) applyStimulus("end.fill", 1, 2'($urandom_range(0, 3)), 0, 0, 0);
        applyStimulus("end.req", 0, 2'd0, 0, 1, 0);
        applyStimulus("end.emit", 0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus("end.drain", 1, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
